// File: rtl/sha256_nonce_feeder.sv
// Walks a nonce range through an external SHA-256 hasher and reports any digest
// strictly below the job target.
//
// state     | meaning
// IDLE      | ready for a new job
// WAIT      | request held to hasher, counting toward timeout
// COMPARE   | captured digest checked against target
// REPORT    | winning nonce/digest offered to consumer
// DRAIN     | request low until hasher drops hash_done
module sha256_nonce_feeder #(
   parameter int unsigned NONCE_LSB = 96,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [511:0] job_block,
   input  logic [255:0] job_target,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_end,
   input  logic         abort,
   output logic         hash_start,
   output logic [511:0] hash_block,
   input  logic         hash_done,
   input  logic [255:0] hash_result,
   output logic         found_valid,
   input  logic         found_ready,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   output logic         exhausted,
   output logic         timeout_err,
   output logic [31:0]  attempts
);

   localparam int unsigned WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_COMPARE,
      S_REPORT,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [511:0]   tmpl_r;
   logic [255:0]   target_r;
   logic [255:0]   result_r;
   logic [31:0]    end_r;
   logic [31:0]    nonce;
   logic [WCW-1:0] wait_cnt;

   logic accept, capture, nonce_inc, win_load, exh_set, tmo_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // abort is tested first in every busy state so it beats done, ready and timeout
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      nonce_inc = 1'b0;
      win_load  = 1'b0;
      exh_set   = 1'b0;
      tmo_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (job_valid) begin
               accept    = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (hash_done) begin
               capture   = 1'b1;
               state_nxt = S_COMPARE;
            end else if (wait_cnt == WAIT_LIMIT) begin
               tmo_set   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_COMPARE: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (result_r < target_r) begin
               win_load  = 1'b1;
               state_nxt = S_REPORT;
            end else if (nonce == end_r) begin
               exh_set   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               nonce_inc = 1'b1;
               state_nxt = S_DRAIN;
            end
         end
         S_REPORT: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (found_ready) begin
               if (nonce == end_r) begin
                  exh_set   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  nonce_inc = 1'b1;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (abort)           state_nxt = S_IDLE;
            else if (!hash_done) state_nxt = S_WAIT;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmpl_r      <= '0;
         target_r    <= '0;
         result_r    <= '0;
         end_r       <= '0;
         nonce       <= '0;
         wait_cnt    <= '0;
         attempts    <= '0;
         found_nonce <= '0;
         found_hash  <= '0;
         exhausted   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         exhausted   <= exh_set;
         timeout_err <= tmo_set;
         wait_cnt    <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + WCW'(1) : '0;
         if (accept) begin
            tmpl_r   <= job_block;
            target_r <= job_target;
            end_r    <= nonce_end;
            nonce    <= nonce_start;
            attempts <= '0;
         end
         if (capture) begin
            result_r <= hash_result;
            if (attempts != '1) attempts <= attempts + 32'd1;
         end
         if (nonce_inc) nonce <= nonce + 32'd1;
         if (win_load) begin
            found_nonce <= nonce;
            found_hash  <= result_r;
         end
      end
   end

   // nonce only moves outside WAIT, so the block is stable while hash_start is high
   always_comb begin
      hash_block                   = tmpl_r;
      hash_block[NONCE_LSB +: 32]  = nonce;
   end

   assign job_ready   = (state == S_IDLE);
   assign hash_start  = (state == S_WAIT);
   assign found_valid = (state == S_REPORT);

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Randomized and directed bench for sha256_nonce_feeder; a nonce-list model and a
// single per-cycle checker judge every request, win, pulse and job summary.
module tb_sha256_nonce_feeder;

   localparam int NL  = 96;
   localparam int TMO = 255;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         job_valid, job_ready, abort, hash_start, hash_done;
   logic         found_valid, found_ready, exhausted, timeout_err;
   logic [511:0] job_block, hash_block;
   logic [255:0] job_target, hash_result, found_hash;
   logic [31:0]  nonce_start, nonce_end, found_nonce, attempts;

   always #5 clk = ~clk;

   sha256_nonce_feeder #(.NONCE_LSB(NL), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_block(job_block),
      .job_target(job_target), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .abort(abort), .hash_start(hash_start), .hash_block(hash_block),
      .hash_done(hash_done), .hash_result(hash_result),
      .found_valid(found_valid), .found_ready(found_ready),
      .found_nonce(found_nonce), .found_hash(found_hash),
      .exhausted(exhausted), .timeout_err(timeout_err), .attempts(attempts)
   );

   // scenario controls and expectations, written only by the main sequence
   int           lat, hold_extra, abort_mode, ready_mode;
   bit           never_done, budget_hit;
   logic [255:0] key;
   logic [511:0] tmpl;
   logic [31:0]  exp_nonce[$];
   logic [31:0]  exp_found[$];
   int           exp_attempts, exp_exh, exp_tmo, exp_req, exp_fnd;
   int           req_seq;

   // checker state, written only by the compare process
   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_seq = 0;
   int ridx, fidx, cur, rise_cyc, n_exh, n_tmo, base_exh, base_tmo;
   bit prev_hs, prev_done, prev_exh, acc_pend, idle_pend;

   function automatic logic [255:0] res_of(input logic [31:0] n, input logic [255:0] k);
      logic [31:0] m;
      m = n * 32'h9E3779B1;
      m = m ^ (m >> 13);
      return k ^ {8{m}};
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // hasher and consumer model
   initial begin : responder
      int cnt;
      int hold_left;
      cnt = 0; hold_left = 0;
      abort = 1'b0; hash_done = 1'b0; hash_result = '0; found_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         abort = 1'b0;
         found_ready = (ready_mode == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         if (!rst_n) begin
            hash_done = 1'b0; cnt = 0; hold_left = 0;
         end else begin
            if (abort_mode == 3 && job_ready)   abort = 1'b1;
            if (abort_mode == 2 && found_valid) abort = 1'b1;
            if (hash_start) begin
               if (!hash_done) begin
                  cnt++;
                  if (!never_done && cnt >= lat) begin
                     hash_done   = 1'b1;
                     hash_result = res_of(hash_block[NL +: 32], key);
                     hold_left   = hold_extra;
                     if (abort_mode == 1) abort = 1'b1;
                  end
               end
            end else begin
               cnt = 0;
               if (hash_done) begin
                  if (hold_left > 0) hold_left--;
                  else hash_done = 1'b0;
               end
            end
         end
      end
   end

   initial begin : compare
      logic [511:0] blk;
      ridx = 0; fidx = 0; cur = 0; rise_cyc = 0; n_exh = 0; n_tmo = 0;
      base_exh = 0; base_tmo = 0;
      prev_hs = 0; prev_done = 0; prev_exh = 0; acc_pend = 0; idle_pend = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (!clk) cyc++;
         if (!rst_n) begin
            chk("rst_job_ready", job_ready, 1);
            chk("rst_hash_start", hash_start, 0);
            chk("rst_found_valid", found_valid, 0);
            chk("rst_exhausted", exhausted, 0);
            chk("rst_timeout_err", timeout_err, 0);
            chk("rst_attempts", attempts, 0);
            chk("rst_found_nonce", found_nonce, 0);
            chk("rst_found_hash", found_hash, 0);
            chk("rst_hash_block", hash_block, 0);
            prev_hs = 0; prev_done = 0; prev_exh = 0; acc_pend = 0; idle_pend = 0;
         end else if (!clk) begin
            if (acc_pend)  chk("accept_to_wait", {job_ready, hash_start}, 2'b01);
            if (idle_pend) chk("abort_to_idle", {job_ready, hash_start, found_valid, exhausted}, 4'b1000);
            acc_pend = 0; idle_pend = 0;
            if (job_valid && job_ready) begin
               acc_pend = 1; ridx = 0; fidx = 0; base_exh = n_exh; base_tmo = n_tmo;
            end
            if (abort && !job_ready) idle_pend = 1;

            chk("busy_vs_ready", job_ready && (hash_start || found_valid), 0);

            if (hash_start) begin
               if (!prev_hs) begin
                  chk("request_after_done_low", prev_done, 0);
                  cur = ridx; ridx++; rise_cyc = cyc;
               end
               if (cur < exp_nonce.size()) begin
                  blk = tmpl;
                  blk[NL +: 32] = exp_nonce[cur];
                  chk("hash_block", hash_block, blk);
               end else begin
                  chk("extra_request", hash_start, 0);
               end
            end

            if (found_valid) begin
               if (fidx < exp_found.size()) begin
                  chk("found_nonce", found_nonce, exp_found[fidx]);
                  chk("found_hash", found_hash, res_of(exp_found[fidx], key));
               end else begin
                  chk("unexpected_found", found_valid, 0);
               end
               if (found_ready) fidx++;
            end

            if (exhausted) begin
               n_exh++;
               chk("exhausted_one_cycle", prev_exh, 0);
               chk("exhausted_in_idle", job_ready, 1);
            end
            if (timeout_err) begin
               n_tmo++;
               chk("timeout_latency", cyc - rise_cyc, TMO + 1);
               chk("timeout_to_idle", {job_ready, hash_start}, 2'b10);
            end

            if (req_seq != done_seq) begin
               done_seq = req_seq;
               chk("job_budget", budget_hit, 0);
               chk("attempts", attempts, 32'(exp_attempts));
               chk("exhausted_count", n_exh - base_exh, exp_exh);
               chk("timeout_count", n_tmo - base_tmo, exp_tmo);
               chk("request_count", ridx, exp_req);
               chk("found_count", fidx, exp_fnd);
            end

            prev_hs = hash_start; prev_done = hash_done; prev_exh = exhausted;
         end
      end
   end

   // nonce list walked from start to end inclusive, wrapping at 2^32
   task automatic build_model(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
      logic [31:0] n;
      n = s;
      exp_nonce.delete();
      exp_found.delete();
      forever begin
         exp_nonce.push_back(n);
         if (res_of(n, key) < tgt) exp_found.push_back(n);
         if (n == e) break;
         n = n + 32'd1;
      end
   endtask

   task automatic offer(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
      @(posedge clk); #1;
      job_block = tmpl; job_target = tgt; nonce_start = s; nonce_end = e; job_valid = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0; job_block = rand512(); job_target = rand256();
      nonce_start = $urandom; nonce_end = $urandom;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      budget_hit = 0;
      @(negedge clk);
      while (!job_ready && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (!job_ready) budget_hit = 1;
      repeat (8) @(negedge clk);
   endtask

   task automatic end_check(input int ea, input int ex, input int et, input int er, input int ef);
      exp_attempts = ea; exp_exh = ex; exp_tmo = et; exp_req = er; exp_fnd = ef;
      req_seq = req_seq + 1;
      for (int i = 0; i < 10 && done_seq != req_seq; i++) @(negedge clk);
      if (done_seq != req_seq) begin
         $display("FAIL end_check_handshake: got %0d want %0d", done_seq, req_seq);
         $fatal(1);
      end
   endtask

   task automatic run_model_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
      build_model(s, e, tgt);
      offer(s, e, tgt);
      wait_idle(3000);
      end_check(exp_nonce.size(), 1, 0, exp_nonce.size(), exp_found.size());
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : main
      logic [31:0]  s, e;
      logic [255:0] tgt;
      int           len;
      job_valid = 0; job_block = '0; job_target = '0; nonce_start = '0; nonce_end = '0;
      lat = 3; hold_extra = 0; abort_mode = 0; ready_mode = 0; never_done = 0;
      key = '0; tmpl = '0; budget_hit = 0; req_seq = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // range 5..7, every digest wins
      key = '0; tmpl = rand512(); lat = 3;
      exp_nonce = '{32'd5, 32'd6, 32'd7};
      exp_found = '{32'd5, 32'd6, 32'd7};
      offer(32'd5, 32'd7, '1);
      wait_idle(3000);
      end_check(3, 1, 0, 3, 3);

      // wrapping range with unreachable target
      key = rand256(); tmpl = rand512(); lat = 2;
      exp_nonce = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
      exp_found.delete();
      offer(32'hFFFFFFFE, 32'h1, '0);
      wait_idle(3000);
      end_check(4, 1, 0, 4, 0);

      // hasher never answers
      never_done = 1; tmpl = rand512();
      build_model(32'd40, 32'd40, '1);
      offer(32'd40, 32'd40, '1);
      wait_idle(600);
      end_check(0, 0, 1, 1, 0);
      never_done = 0;

      // hash_done held several cycles past each result
      key = rand256(); tmpl = rand512(); lat = 2; hold_extra = 4;
      run_model_job(32'd20, 32'd22, {32'h80000000, 224'd0});
      hold_extra = 0;

      // abort coincident with hash_done
      key = '0; tmpl = rand512(); abort_mode = 1;
      build_model(32'd3, 32'd9, '1);
      offer(32'd3, 32'd9, '1);
      wait_idle(500);
      end_check(0, 0, 0, 1, 0);

      // abort while a win is pending
      abort_mode = 2; ready_mode = 1; tmpl = rand512();
      build_model(32'd3, 32'd4, '1);
      offer(32'd3, 32'd4, '1);
      wait_idle(500);
      end_check(1, 0, 0, 1, 0);
      abort_mode = 0; ready_mode = 0;

      // reset pulse in WAIT
      never_done = 1; tmpl = rand512();
      build_model(32'd50, 32'd52, '1);
      offer(32'd50, 32'd52, '1);
      @(posedge clk); #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      never_done = 0;
      repeat (6) @(negedge clk);
      end_check(0, 0, 0, 1, 0);

      // abort and job_valid together in IDLE: job still taken
      abort_mode = 3; key = rand256(); tmpl = rand512(); lat = 1;
      run_model_job(32'd100, 32'd101, rand256());
      abort_mode = 0;

      // digest equal to target is not a win
      key = rand256(); tmpl = rand512(); lat = 2;
      run_model_job(32'd10, 32'd11, res_of(32'd10, key));

      // single-nonce range
      key = '0; tmpl = rand512();
      exp_nonce = '{32'd77};
      exp_found = '{32'd77};
      offer(32'd77, 32'd77, '1);
      wait_idle(500);
      end_check(1, 1, 0, 1, 1);

      for (int j = 0; j < 25; j++) begin
         key = rand256(); tmpl = rand512();
         lat = $urandom_range(1, 6); hold_extra = $urandom_range(0, 3);
         s = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 4))) : 32'($urandom);
         len = $urandom_range(1, 6);
         e = s + 32'(len) - 32'd1;
         tgt = rand256();
         run_model_job(s, e, tgt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
